// File: rtl/pdm_adc_decimator.sv
// PDM receive decimator: synchroniser, boxcar ones-counter (CIC1) or 2nd-order CIC, scaler, 1-entry output register.
// Define PDM_DECIM_CIC2_EN to build the 2nd-order CIC instead of the boxcar.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_SYNC0 | synchroniser holds reset value, bit not consumed
// ST_SYNC1 | synchroniser half filled, bit not consumed
// ST_FILL  | CIC2 only: first window primes the combs, no sample emitted
// ST_RUN   | bits consumed, sample emitted at every window end
module pdm_adc_decimator #(
    parameter int DATA_BITS  = 12,
    parameter int DECIM_LOG2 = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pdm_in,
    input  logic                 clk_en,
    output logic [DATA_BITS-1:0] sample_out,
    output logic                 sample_valid,
    input  logic                 sample_ready,
    output logic                 overrun,
    input  logic                 overrun_clr
);

    localparam int L = DECIM_LOG2;
    localparam int D = DATA_BITS;
    localparam logic [L-1:0] CNT_LAST = '1;

    typedef enum logic [1:0] {ST_SYNC0, ST_SYNC1, ST_FILL, ST_RUN} state_t;

`ifdef PDM_DECIM_CIC2_EN
    localparam state_t ST_AFTER_SYNC = ST_FILL;
`else
    localparam state_t ST_AFTER_SYNC = ST_RUN;
`endif

    state_t         state;
    state_t         state_nxt;
    logic           sync_a;
    logic           sync_b;
    logic [L-1:0]   cnt;
    logic           consume;
    logic           window_end;
    logic           load;
    logic [D-1:0]   sample_new;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
        end else begin
            sync_a <= pdm_in;
            sync_b <= sync_a;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_SYNC0;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_SYNC0: if (clk_en) state_nxt = ST_SYNC1;
            ST_SYNC1: if (clk_en) state_nxt = ST_AFTER_SYNC;
            ST_FILL:  if (window_end) state_nxt = ST_RUN;
            default:  state_nxt = state;
        endcase
    end

    always_comb begin
        consume    = clk_en && (state == ST_FILL || state == ST_RUN);
        window_end = consume && (cnt == CNT_LAST);
        load       = window_end && (state == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (consume) begin
            cnt <= cnt + 1'b1;
        end
    end

`ifdef PDM_DECIM_CIC2_EN
    localparam int W = 2 * L + 1;
    localparam logic [W-1:0] FULL2 = {1'b1, {(2 * L){1'b0}}};

    logic [W-1:0] integ1;
    logic [W-1:0] integ2;
    logic [W-1:0] comb_z1;
    logic [W-1:0] comb_z2;
    logic [W-1:0] integ1_nxt;
    logic [W-1:0] integ2_nxt;
    logic [W-1:0] comb1;
    logic [W-1:0] raw;
    logic [D-1:0] raw_scaled;

    // The current bit enters both integrators before the comb sees them, so the Nth bit lands in its own window.
    assign integ1_nxt = integ1 + {{(W - 1){1'b0}}, sync_b};
    assign integ2_nxt = integ2 + integ1_nxt;
    assign comb1      = integ2_nxt - comb_z1;
    assign raw        = comb1 - comb_z2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            integ1  <= '0;
            integ2  <= '0;
            comb_z1 <= '0;
            comb_z2 <= '0;
        end else if (consume) begin
            integ1 <= integ1_nxt;
            integ2 <= integ2_nxt;
            if (window_end) begin
                comb_z1 <= integ2_nxt;
                comb_z2 <= comb1;
            end
        end
    end

    generate
        if (2 * L >= D) begin : g_scale_down
            assign raw_scaled = raw[2 * L - 1 -: D];
        end else begin : g_scale_up
            assign raw_scaled = {raw[2 * L - 1:0], {(D - 2 * L){1'b0}}};
        end
    endgenerate

    assign sample_new = (raw == FULL2) ? {D{1'b1}} : raw_scaled;
`else
    localparam logic [L:0] FULL1 = {1'b1, {L{1'b0}}};

    logic [L:0]   ones;
    logic [L:0]   ones_nxt;
    logic [D-1:0] ones_scaled;

    assign ones_nxt = ones + {{L{1'b0}}, sync_b};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ones <= '0;
        end else if (consume) begin
            ones <= window_end ? '0 : ones_nxt;
        end
    end

    generate
        if (D > L) begin : g_scale_up
            assign ones_scaled = {ones_nxt[L-1:0], {(D - L){1'b0}}};
        end else begin : g_scale_none
            assign ones_scaled = ones_nxt[L-1:0];
        end
    endgenerate

    assign sample_new = (ones_nxt == FULL1) ? {D{1'b1}} : ones_scaled;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sample_out   <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (load) begin
                sample_out   <= sample_new;
                sample_valid <= 1'b1;
            end else if (sample_valid && sample_ready) begin
                sample_valid <= 1'b0;
            end
            // A new overrun takes priority over a simultaneous clear.
            if (load && sample_valid && !sample_ready) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pdm_adc_decimator.sv
// Directed bench for pdm_adc_decimator (default CIC1 build, DATA_BITS=12, DECIM_LOG2=8).
module tb_pdm_adc_decimator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pdm_in = 1'b0;
    logic        clk_en = 1'b1;
    logic [11:0] sample_out;
    logic        sample_valid;
    logic        sample_ready = 1'b1;
    logic        overrun;
    logic        overrun_clr = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    // Input source: 0 = constant low, 1 = constant high, 2 = first-order DAC model of dac_din.
    int          mode = 0;
    int          en_div = 1;
    int          en_ph = 0;
    logic [11:0] dac_acc = '0;
    logic [11:0] dac_din = '0;
    int          n;

    pdm_adc_decimator dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pdm_in       (pdm_in),
        .clk_en       (clk_en),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overrun      (overrun),
        .overrun_clr  (overrun_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        logic [12:0] sum;
        @(negedge clk);
        case (mode)
            0: pdm_in = 1'b0;
            1: pdm_in = 1'b1;
            default: begin
                sum     = {1'b0, dac_acc} + {1'b0, dac_din};
                dac_acc = sum[11:0];
                pdm_in  = sum[12];
            end
        endcase
        en_ph  = (en_ph + 1) % en_div;
        clk_en = (en_ph == 0);
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        repeat (cycles) step();
        rst_n  = 1'b1;
        en_ph  = 0;
        clk_en = 1'b1;
    endtask

    task automatic wait_valid(input string tag, input int max, output int cycles);
        cycles = 0;
        do begin
            step();
            cycles++;
        end while (!sample_valid && cycles < max);
        chk(tag, {31'd0, sample_valid}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] dins [3];
        logic [11:0] exps [3];
        dins = '{12'h800, 12'h400, 12'h100};
        exps = '{12'h800, 12'h400, 12'h100};

        // Reset state
        @(negedge clk);
        repeat (3) step();
        chk("rst_sample", 32'(sample_out), 0);
        chk("rst_valid", 32'(sample_valid), 0);
        chk("rst_overrun", 32'(overrun), 0);

        // Constant zero stream
        mode = 0;
        do_reset(2);
        wait_valid("zero_v1", 400, n);
        chk("zero_first_lat", n, 258);
        chk("zero_first_val", 32'(sample_out), 12'h000);
        wait_valid("zero_v2", 400, n);
        chk("zero_period", n, 256);
        chk("zero_val2", 32'(sample_out), 12'h000);
        chk("zero_overrun", 32'(overrun), 0);

        // Constant one stream saturates
        mode = 1;
        pdm_in = 1'b1;
        do_reset(2);
        wait_valid("ones_v1", 400, n);
        chk("ones_first_lat", n, 258);
        chk("ones_first_val", 32'(sample_out), 12'hFFF);
        wait_valid("ones_v2", 400, n);
        chk("ones_period", n, 256);
        chk("ones_val2", 32'(sample_out), 12'hFFF);

        // DAC loopback for dins whose 256-bit ones count is phase independent
        for (int k = 0; k < 3; k++) begin
            mode    = 2;
            dac_din = dins[k];
            dac_acc = '0;
            do_reset(2);
            for (int w = 0; w < 3; w++) begin
                wait_valid($sformatf("dac%0d_v%0d", k, w), 400, n);
                chk($sformatf("dac%0d_val%0d", k, w), 32'(sample_out), 32'(exps[k]));
            end
        end

        // Overrun: window 1 all zeros, window 2 has two stale zeros from the synchroniser
        mode = 0;
        sample_ready = 1'b0;
        do_reset(2);
        wait_valid("ovr_v1", 400, n);
        chk("ovr_first_val", 32'(sample_out), 12'h000);
        mode = 1;
        pdm_in = 1'b1;
        repeat (255) step();
        chk("ovr_hold_val", 32'(sample_out), 12'h000);
        chk("ovr_hold_flag", 32'(overrun), 0);
        step();
        chk("ovr_set", 32'(overrun), 1);
        chk("ovr_latest", 32'(sample_out), 12'hFE0);
        chk("ovr_valid", 32'(sample_valid), 1);
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        chk("ovr_clr", 32'(overrun), 0);
        chk("ovr_clr_valid", 32'(sample_valid), 1);
        sample_ready = 1'b1;
        step();
        chk("ready_drop", 32'(sample_valid), 0);
        sample_ready = 1'b0;
        wait_valid("ovr_v3", 400, n);
        chk("load_idle_lat", n, 254);
        chk("load_idle_val", 32'(sample_out), 12'hFFF);
        chk("load_idle_ovr", 32'(overrun), 0);
        overrun_clr = 1'b1;
        repeat (255) step();
        chk("setwins_pre", 32'(overrun), 0);
        step();
        chk("setwins", 32'(overrun), 1);
        step();
        chk("setwins_after", 32'(overrun), 0);
        overrun_clr = 1'b0;
        sample_ready = 1'b1;

        // Sparse enable: one enabled cycle in 16
        mode = 1;
        en_div = 16;
        do_reset(2);
        wait_valid("sparse_v1", 5000, n);
        chk("sparse_first_lat", n, 4113);
        chk("sparse_val", 32'(sample_out), 12'hFFF);
        step();
        chk("sparse_drop", 32'(sample_valid), 0);
        wait_valid("sparse_v2", 5000, n);
        chk("sparse_period", n, 4095);
        chk("sparse_val2", 32'(sample_out), 12'hFFF);
        en_div = 1;

        // Reset mid-window discards 100 ones already counted
        mode = 1;
        sample_ready = 1'b0;
        do_reset(2);
        wait_valid("mid_v1", 400, n);
        chk("mid_first_val", 32'(sample_out), 12'hFFF);
        repeat (100) step();
        rst_n = 1'b0;
        mode = 0;
        pdm_in = 1'b0;
        step();
        chk("mid_rst_sample", 32'(sample_out), 0);
        chk("mid_rst_valid", 32'(sample_valid), 0);
        chk("mid_rst_overrun", 32'(overrun), 0);
        rst_n  = 1'b1;
        en_ph  = 0;
        clk_en = 1'b1;
        sample_ready = 1'b1;
        wait_valid("mid_v2", 400, n);
        chk("mid_lat", n, 258);
        chk("mid_val", 32'(sample_out), 12'h000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
